// File: rtl/divider_seq_pkg.sv
// Shared definitions for the step sequencer: the FSM state type and the
// counter-width helper.
package divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // Bits needed to hold the value itself, so exact powers of two get one extra
  // bit: ceil_log2(16) = 5.
  function automatic int ceil_log2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/step_sequencer.sv
// Run-length step sequencer: counts Leff steps up or down under enable,
// then emits a one-cycle done pulse. Abort and reset drop the run silently.
module step_sequencer
  import divider_seq_pkg::*;
#(
  parameter int MAX_COUNT         = 32,
  parameter int NBITS_FOR_COUNTER = ceil_log2(MAX_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NBITS_FOR_COUNTER-1:0] limit,
  input  logic                         down,
  input  logic                         enable,
  input  logic                         abort,
  output logic [NBITS_FOR_COUNTER-1:0] count,
  output logic                         busy,
  output logic                         first,
  output logic                         last,
  output logic                         done
);

  localparam int N = NBITS_FOR_COUNTER;
  localparam logic [N-1:0] MAX_L = N'(MAX_COUNT);
  localparam logic [N-1:0] ONE   = N'(1);

  seq_state_t   state;
  logic [N-1:0] len_q;
  logic         dir_q;

  logic [N-1:0] limit_eff;
  logic [N-1:0] start_val;
  logic [N-1:0] end_val;
  logic [N-1:0] next_step;

  // A zero or oversized limit means "full length".
  always_comb begin
    limit_eff = limit;
    if (limit == '0 || limit > MAX_L) limit_eff = MAX_L;
  end

  always_comb begin
    start_val = dir_q ? (len_q - ONE) : '0;
    end_val   = dir_q ? '0 : (len_q - ONE);
    next_step = dir_q ? (count - ONE) : (count + ONE);
  end

  assign busy  = (state == RUN);
  assign first = busy && (count == start_val);
  assign last  = busy && (count == end_val);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      len_q <= MAX_L;
      dir_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            len_q <= limit_eff;
            dir_q <= down;
            count <= down ? (limit_eff - ONE) : '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            count <= '0;
            state <= IDLE;
          end else if (enable) begin
            // Count holds at the end value through DONE rather than wrapping.
            if (count == end_val) state <= DONE;
            else                  count <= next_step;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
